// File: rtl/axi_wr_pkg.sv
// Shared types and encodings for the AXI write-channel to LiteDRAM native bridge.
package axi_wr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
   localparam logic [1:0] BURST_RSVD  = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   localparam int unsigned LEN_W = 8;
   localparam int unsigned CNT_W = 9;

   // Burst shape latched from AW for the life of one burst
   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [1:0]       burst;
   } burst_ctl_t;

   // Only power-of-two burst lengths can wrap
   function automatic logic is_wrap_len(input logic [LEN_W-1:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr_next.sv
// Next native beat address for FIXED / INCR / WRAP bursts (reserved behaves as INCR).
module axi_burst_addr_next
   import axi_wr_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] cur_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [1:0]        burst_i,
   output logic [ADDR_W-1:0] next_o
);

   logic [ADDR_W-1:0] mask;
   logic [ADDR_W-1:0] inc;

   always_comb begin
      mask   = ADDR_W'(len_i);
      inc    = cur_i + ADDR_W'(1);
      next_o = inc;
      case (burst_i)
         BURST_FIXED: next_o = cur_i;
         BURST_WRAP:  next_o = (cur_i & ~mask) | (inc & mask);
         default:     next_o = inc;
      endcase
   end

endmodule

// File: rtl/axi_wr_native_bridge.sv
// AXI4 AW/W/B responder issuing per-beat LiteDRAM native write commands and data.
// Optional B response checking is enabled by defining AXI_WR_BRESP_CHECK_EN.
module axi_wr_native_bridge
   import axi_wr_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 256,
   parameter int unsigned ID_W       = 1,
   parameter int unsigned BEAT_SHIFT = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                axi_aw_valid,
   output logic                axi_aw_ready,
   input  logic [ADDR_W-1:0]   axi_aw_payload_addr,
   input  logic [1:0]          axi_aw_payload_burst,
   input  logic [7:0]          axi_aw_payload_len,
   input  logic [3:0]          axi_aw_payload_size,
   input  logic [ID_W-1:0]     axi_aw_payload_id,
   input  logic                axi_w_valid,
   output logic                axi_w_ready,
   input  logic                axi_w_last,
   input  logic [DATA_W-1:0]   axi_w_payload_data,
   input  logic [DATA_W/8-1:0] axi_w_payload_strb,
   output logic                axi_b_valid,
   input  logic                axi_b_ready,
   output logic [1:0]          axi_b_payload_resp,
   output logic [ID_W-1:0]     axi_b_payload_id,
   output logic                native_cmd_valid,
   input  logic                native_cmd_ready,
   output logic                native_cmd_payload_we,
   output logic [ADDR_W-1:0]   native_cmd_payload_addr,
   output logic                wdata_valid,
   input  logic                wdata_ready,
   output logic [DATA_W-1:0]   wdata_payload_data,
   output logic [DATA_W/8-1:0] wdata_payload_we
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   burst_ctl_t        ctl_q, ctl_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
   logic [CNT_W-1:0]  dat_cnt_q, dat_cnt_d;

   logic [ADDR_W-1:0] next_addr;
   logic [CNT_W-1:0]  len_ext;
   logic              cmd_open, dat_open;
   logic              aw_fire, cmd_fire, w_fire;

   axi_burst_addr_next #(
      .ADDR_W (ADDR_W)
   ) u_addr_next (
      .cur_i   (addr_q),
      .len_i   (ctl_q.len),
      .burst_i (ctl_q.burst),
      .next_o  (next_addr)
   );

   // Command and data sides drain independently, each bounded to len+1 beats
   assign len_ext  = CNT_W'(ctl_q.len);
   assign cmd_open = (state_q == BURST) && (cmd_cnt_q <= len_ext);
   assign dat_open = (state_q == BURST) && (dat_cnt_q <= len_ext);

   assign axi_aw_ready            = (state_q == IDLE);
   assign native_cmd_valid        = cmd_open;
   assign native_cmd_payload_we   = cmd_open;
   assign native_cmd_payload_addr = addr_q;
   assign axi_w_ready             = dat_open & wdata_ready;
   assign wdata_valid             = dat_open & axi_w_valid;
   assign wdata_payload_data      = axi_w_payload_data;
   assign wdata_payload_we        = axi_w_payload_strb;
   assign axi_b_valid             = (state_q == RESP);
   assign axi_b_payload_id        = id_q;

   assign aw_fire  = axi_aw_valid & axi_aw_ready;
   assign cmd_fire = native_cmd_valid & native_cmd_ready;
   assign w_fire   = axi_w_valid & axi_w_ready;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      ctl_d     = ctl_q;
      id_d      = id_q;
      cmd_cnt_d = cmd_cnt_q;
      dat_cnt_d = dat_cnt_q;
      case (state_q)
         IDLE: begin
            if (aw_fire) begin
               addr_d      = axi_aw_payload_addr >> BEAT_SHIFT;
               ctl_d.len   = axi_aw_payload_len;
               ctl_d.burst = axi_aw_payload_burst;
               id_d        = axi_aw_payload_id;
               cmd_cnt_d   = '0;
               dat_cnt_d   = '0;
               state_d     = BURST;
            end
         end
         BURST: begin
            if (cmd_fire) begin
               cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
               addr_d    = next_addr;
            end
            if (w_fire) begin
               dat_cnt_d = dat_cnt_q + CNT_W'(1);
            end
            // Same-cycle final handshakes are already folded into the _d counts
            if ((cmd_cnt_d > len_ext) && (dat_cnt_d > len_ext)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (axi_b_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         ctl_q     <= '0;
         id_q      <= '0;
         cmd_cnt_q <= '0;
         dat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         ctl_q     <= ctl_d;
         id_q      <= id_d;
         cmd_cnt_q <= cmd_cnt_d;
         dat_cnt_q <= dat_cnt_d;
      end
   end

`ifdef AXI_WR_BRESP_CHECK_EN
   logic err_q, err_d;
   logic aw_err, w_err;

   // Protocol violations are sticky for the burst and only change the B response
   always_comb begin
      aw_err = (axi_aw_payload_burst == BURST_RSVD) ||
               (axi_aw_payload_size != 4'(BEAT_SHIFT)) ||
               ((axi_aw_payload_burst == BURST_WRAP) && !is_wrap_len(axi_aw_payload_len));
      w_err  = axi_w_last != (dat_cnt_q == len_ext);
      err_d  = err_q;
      if ((state_q == IDLE) && aw_fire) begin
         err_d = aw_err;
      end else if ((state_q == BURST) && w_fire && w_err) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign axi_b_payload_resp = ((state_q == RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
`else
   logic unused_chk;

   assign unused_chk         = ^{axi_aw_payload_size, axi_w_last};
   assign axi_b_payload_resp = RESP_OKAY;
`endif

endmodule

// File: tb/tb_axi_wr_native_bridge.sv
// Scoreboard bench for axi_wr_native_bridge: directed bursts, backpressure and reset.
module tb_axi_wr_native_bridge;

   logic         clk;
   logic         rst;
   logic         axi_aw_valid, axi_aw_ready;
   logic [31:0]  axi_aw_payload_addr;
   logic [1:0]   axi_aw_payload_burst;
   logic [7:0]   axi_aw_payload_len;
   logic [3:0]   axi_aw_payload_size;
   logic [0:0]   axi_aw_payload_id;
   logic         axi_w_valid, axi_w_ready, axi_w_last;
   logic [255:0] axi_w_payload_data;
   logic [31:0]  axi_w_payload_strb;
   logic         axi_b_valid, axi_b_ready;
   logic [1:0]   axi_b_payload_resp;
   logic [0:0]   axi_b_payload_id;
   logic         native_cmd_valid, native_cmd_ready, native_cmd_payload_we;
   logic [31:0]  native_cmd_payload_addr;
   logic         wdata_valid, wdata_ready;
   logic [255:0] wdata_payload_data;
   logic [31:0]  wdata_payload_we;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]  exp_addr[$];
   logic [255:0] exp_data[$];
   logic [31:0]  exp_strb[$];
   logic [2:0]   exp_b[$];

`ifdef AXI_WR_BRESP_CHECK_EN
   localparam logic [1:0] BAD_LAST_RESP = 2'd2;
`else
   localparam logic [1:0] BAD_LAST_RESP = 2'd0;
`endif

   axi_wr_native_bridge dut (
      .clk                     (clk),
      .rst                     (rst),
      .axi_aw_valid            (axi_aw_valid),
      .axi_aw_ready            (axi_aw_ready),
      .axi_aw_payload_addr     (axi_aw_payload_addr),
      .axi_aw_payload_burst    (axi_aw_payload_burst),
      .axi_aw_payload_len      (axi_aw_payload_len),
      .axi_aw_payload_size     (axi_aw_payload_size),
      .axi_aw_payload_id       (axi_aw_payload_id),
      .axi_w_valid             (axi_w_valid),
      .axi_w_ready             (axi_w_ready),
      .axi_w_last              (axi_w_last),
      .axi_w_payload_data      (axi_w_payload_data),
      .axi_w_payload_strb      (axi_w_payload_strb),
      .axi_b_valid             (axi_b_valid),
      .axi_b_ready             (axi_b_ready),
      .axi_b_payload_resp      (axi_b_payload_resp),
      .axi_b_payload_id        (axi_b_payload_id),
      .native_cmd_valid        (native_cmd_valid),
      .native_cmd_ready        (native_cmd_ready),
      .native_cmd_payload_we   (native_cmd_payload_we),
      .native_cmd_payload_addr (native_cmd_payload_addr),
      .wdata_valid             (wdata_valid),
      .wdata_ready             (wdata_ready),
      .wdata_payload_data      (wdata_payload_data),
      .wdata_payload_we        (wdata_payload_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event/timeout expected none at %0t", nm, $time);
   endfunction

   function automatic logic [255:0] mk_data(input int tag, input int beat);
      logic [31:0] w;
      w = 32'hA5A5_0000 ^ 32'((tag << 8) | beat);
      return {8{w}};
   endfunction

   function automatic logic [31:0] mk_strb(input int tag, input int beat);
      return 32'h0F0F_0F0F ^ 32'((tag << 8) | beat);
   endfunction

   // Monitor: every handshake the DUT presents is checked against the scoreboard
   always @(negedge clk) begin
      if (native_cmd_valid && native_cmd_ready) begin
         if (exp_addr.size() == 0) fail_now("cmd_unexpected");
         else begin
            chk("cmd_addr", native_cmd_payload_addr, exp_addr.pop_front());
            chk("cmd_we", native_cmd_payload_we, 1);
         end
      end
      if (wdata_valid && wdata_ready) begin
         if (exp_data.size() == 0) fail_now("wdata_unexpected");
         else begin
            chk("wdata_data", wdata_payload_data, exp_data.pop_front());
            chk("wdata_we", wdata_payload_we, exp_strb.pop_front());
         end
      end
      if (axi_b_valid && axi_b_ready) begin
         if (exp_b.size() == 0) fail_now("b_unexpected");
         else begin
            logic [2:0] e;
            e = exp_b.pop_front();
            chk("b_resp", axi_b_payload_resp, e[2:1]);
            chk("b_id", axi_b_payload_id, e[0]);
         end
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_aw_ready"}, axi_aw_ready, 1);
      chk({tag, "_cmd_valid"}, native_cmd_valid, 0);
      chk({tag, "_w_ready"}, axi_w_ready, 0);
      chk({tag, "_wdata_valid"}, wdata_valid, 0);
      chk({tag, "_b_valid"}, axi_b_valid, 0);
      chk({tag, "_b_resp"}, axi_b_payload_resp, 0);
   endtask

   task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic id);
      int t = 0;
      axi_aw_valid         = 1'b1;
      axi_aw_payload_addr  = addr;
      axi_aw_payload_len   = len;
      axi_aw_payload_burst = burst;
      axi_aw_payload_size  = 4'd5;
      axi_aw_payload_id    = id;
      do begin @(negedge clk); t++; end while (!axi_aw_ready && t < 200);
      if (t >= 200) fail_now("aw_timeout");
      @(posedge clk); #1;
      axi_aw_valid = 1'b0;
   endtask

   task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id, input int last_beat, input int tag,
                           input int cmd_stall, input bit wtoggle, input int b_stall);
      int t;
      for (int i = 0; i <= int'(len); i++) begin
         exp_data.push_back(mk_data(tag, i));
         exp_strb.push_back(mk_strb(tag, i));
      end
      axi_b_ready = 1'b0;
      drive_aw(addr, len, burst, id);
      fork
         begin
            for (int i = 0; i <= int'(len); i++) begin
               int tw = 0;
               axi_w_valid        = 1'b1;
               axi_w_payload_data = mk_data(tag, i);
               axi_w_payload_strb = mk_strb(tag, i);
               axi_w_last         = (i == last_beat);
               do begin @(negedge clk); tw++; end while (!axi_w_ready && tw < 200);
               if (tw >= 200) fail_now("w_timeout");
               @(posedge clk); #1;
            end
            axi_w_valid = 1'b0;
            axi_w_last  = 1'b0;
         end
         begin
            native_cmd_ready = 1'b0;
            repeat (cmd_stall) @(posedge clk);
            #1 native_cmd_ready = 1'b1;
         end
         begin
            wdata_ready = 1'b1;
            if (wtoggle) begin
               for (int k = 0; k < 40; k++) begin
                  @(posedge clk); #1 wdata_ready = ~wdata_ready;
               end
               wdata_ready = 1'b1;
            end
         end
      join
      t = 0;
      while (!axi_b_valid && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) fail_now("b_timeout");
      repeat (b_stall) begin
         @(posedge clk); @(negedge clk);
         chk("b_valid_held", axi_b_valid, 1);
      end
      @(posedge clk); #1 axi_b_ready = 1'b1;
      @(posedge clk); #1 axi_b_ready = 1'b0;
      @(negedge clk);
      chk("aw_ready_after_b", axi_aw_ready, 1);
      chk("b_valid_after_b", axi_b_valid, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end expected finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      axi_aw_valid = 1'b0; axi_aw_payload_addr = '0; axi_aw_payload_burst = '0;
      axi_aw_payload_len = '0; axi_aw_payload_size = 4'd5; axi_aw_payload_id = '0;
      axi_w_valid = 1'b0; axi_w_last = 1'b0; axi_w_payload_data = '0; axi_w_payload_strb = '0;
      axi_b_ready = 1'b0; native_cmd_ready = 1'b0; wdata_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1 rst = 1'b1;

      // INCR 0x1000 len 3 id 1
      for (int i = 0; i < 4; i++) exp_addr.push_back(32'h80 + 32'(i));
      exp_b.push_back({2'd0, 1'b1});
      do_burst(32'h1000, 8'd3, 2'd1, 1'b1, 3, 1, 0, 1'b0, 0);

      // WRAP from beat 0x107 within a 4-beat block
      exp_addr.push_back(32'h107); exp_addr.push_back(32'h104);
      exp_addr.push_back(32'h105); exp_addr.push_back(32'h106);
      exp_b.push_back({2'd0, 1'b0});
      do_burst(32'h20E0, 8'd3, 2'd2, 1'b0, 3, 2, 0, 1'b0, 0);

      // FIXED keeps the same beat address
      for (int i = 0; i < 3; i++) exp_addr.push_back(32'h28);
      exp_b.push_back({2'd0, 1'b1});
      do_burst(32'h500, 8'd2, 2'd0, 1'b1, 2, 3, 0, 1'b0, 0);

      // Backpressure on both native channels and on B
      for (int i = 0; i < 4; i++) exp_addr.push_back(32'h200 + 32'(i));
      exp_b.push_back({2'd0, 1'b0});
      do_burst(32'h4000, 8'd3, 2'd1, 1'b0, 3, 4, 5, 1'b1, 4);

      // Early w_last: all beats still forwarded, response depends on checking build
      for (int i = 0; i < 4; i++) exp_addr.push_back(32'h180 + 32'(i));
      exp_b.push_back({BAD_LAST_RESP, 1'b1});
      do_burst(32'h3000, 8'd3, 2'd1, 1'b1, 1, 5, 0, 1'b0, 0);

      // Reset in the middle of a len 7 burst
      native_cmd_ready = 1'b0; wdata_ready = 1'b0;
      axi_w_valid = 1'b1; axi_w_payload_data = mk_data(8, 0); axi_w_last = 1'b0;
      drive_aw(32'h8000, 8'd7, 2'd1, 1'b0);
      @(negedge clk);
      chk("first_cmd_latency", native_cmd_valid, 1);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_idle("midreset");
      @(posedge clk); #1 rst = 1'b1; axi_w_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("no_b_after_reset", axi_b_valid, 0);
      end
      @(posedge clk); #1;

      // Single-beat burst: AW at cycle 0, B at cycle 2
      exp_addr.push_back(32'h3);
      exp_data.push_back(mk_data(9, 0));
      exp_strb.push_back(mk_strb(9, 0));
      exp_b.push_back({2'd0, 1'b1});
      native_cmd_ready = 1'b1; wdata_ready = 1'b1; axi_b_ready = 1'b0;
      axi_w_valid = 1'b1; axi_w_payload_data = mk_data(9, 0);
      axi_w_payload_strb = mk_strb(9, 0); axi_w_last = 1'b1;
      drive_aw(32'h60, 8'd0, 2'd1, 1'b1);
      @(negedge clk);
      chk("len0_cmd_cycle1", native_cmd_valid, 1);
      chk("len0_b_cycle1", axi_b_valid, 0);
      @(posedge clk); #1 axi_w_valid = 1'b0; axi_w_last = 1'b0;
      @(negedge clk);
      chk("len0_b_cycle2", axi_b_valid, 1);
      @(posedge clk); #1 axi_b_ready = 1'b1;
      @(posedge clk); #1 axi_b_ready = 1'b0;
      repeat (2) @(posedge clk);

      chk("cmd_queue_drained", 256'(exp_addr.size()), 0);
      chk("data_queue_drained", 256'(exp_data.size()), 0);
      chk("b_queue_drained", 256'(exp_b.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
